// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : encoder_pkg
// Brief   : Shared constants and FSM state type for the 4-to-2 sequential encoder.
// Revision: 1.0
// ============================================================================
package encoder_pkg;

  localparam int NUM_LINES = 4;
  localparam int IDX_W     = 2;

  // Round-robin pointer value after reset; the search starts at line 0.
  localparam logic [IDX_W-1:0] PTR_RESET = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/encoder4to2_pick.sv
`default_nettype none
// ============================================================================
// Module  : encoder4to2_pick
// Brief   : Combinational selector over the pending bitmap; fixed priority
//           (highest index wins), or round-robin when ENCODER_RR_EN is defined.
// Revision: 1.0
// ============================================================================
module encoder4to2_pick
  import encoder_pkg::*;
(
  input  logic [NUM_LINES-1:0] pend,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     idx,
  output logic                 found
);

`ifdef ENCODER_RR_EN
  logic [IDX_W-1:0] w_cand;

  // Walk offsets from far to near so the line nearest after ptr is written last.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    w_cand = '0;
    for (int k = NUM_LINES; k >= 1; k--) begin
      w_cand = ptr + k[IDX_W-1:0];
      if (pend[w_cand]) begin
        idx   = w_cand;
        found = 1'b1;
      end
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^ptr;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (pend[i]) begin
        idx   = i[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/encoder4to2_seq.sv
`default_nettype none
// ============================================================================
// Module  : encoder4to2_seq
// Brief   : Sequential 4-to-2 encoder: latches request lines into a pending
//           bitmap and presents one code at a time under a valid/ack handshake.
//           Define ENCODER_RR_EN for round-robin selection.
// Revision: 1.0
// ============================================================================
module encoder4to2_seq
  import encoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 y0,
  input  logic                 y1,
  input  logic                 y2,
  input  logic                 y3,
  input  logic                 en,
  input  logic                 ack,
  output logic                 o0,
  output logic                 o1,
  output logic                 valid,
  output logic [NUM_LINES-1:0] pend
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NUM_LINES-1:0]   r_pend;
  logic [NUM_LINES-1:0]   w_pend_nxt;
  logic [IDX_W-1:0]       r_code;
  logic [IDX_W-1:0]       w_code_nxt;
  logic [NUM_LINES-1:0]   w_y;
  logic [IDX_W-1:0]       w_ptr;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_found;
  logic                   w_load;

  assign w_y = {y3, y2, y1, y0};

  encoder4to2_pick u_pick (
    .pend  (r_pend),
    .ptr   (w_ptr),
    .idx   (w_idx),
    .found (w_found)
  );

`ifdef ENCODER_RR_EN
  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PTR_RESET;
    end else if (w_load) begin
      r_ptr <= w_idx;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = PTR_RESET;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_code  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_code  <= w_code_nxt;
    end
  end

  // en=0 freezes loading; an ack in HOLD still retires the presented code.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_code_nxt  = r_code;
    w_load      = en && w_found && ((r_state == IDLE) || ack);
    if (w_load) begin
      w_state_nxt        = HOLD;
      w_code_nxt         = w_idx;
      w_pend_nxt[w_idx]  = 1'b0;
    end else if ((r_state == HOLD) && ack) begin
      w_state_nxt = IDLE;
    end
    // Capture after the clear so a re-asserted line stays pending.
    if (en) begin
      w_pend_nxt = w_pend_nxt | w_y;
    end
  end

  assign valid = (r_state == HOLD);
  assign o0    = r_code[1];
  assign o1    = r_code[0];
  assign pend  = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_encoder4to2_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_encoder4to2_seq
// Brief   : Scoreboard bench for encoder4to2_seq with a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_encoder4to2_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       y0, y1, y2, y3;
  logic       en, ack;
  logic       o0, o1, valid;
  logic [3:0] pend;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
    logic [3:0] pend;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model state
  logic [3:0] m_pend;
  logic       m_valid;
  logic [1:0] m_code;
  int         m_last;

  encoder4to2_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .y0    (y0),
    .y1    (y1),
    .y2    (y2),
    .y3    (y3),
    .en    (en),
    .ack   (ack),
    .o0    (o0),
    .o1    (o1),
    .valid (valid),
    .pend  (pend)
  );

  always #5 clk = ~clk;

  function automatic int choose(input logic [3:0] p, input int last);
    int sel;
    sel = -1;
`ifdef ENCODER_RR_EN
    for (int k = 1; k <= 4; k++) begin
      if (sel < 0 && p[(last + k) % 4]) sel = (last + k) % 4;
    end
`else
    for (int n = 3; n >= 0; n--) begin
      if (sel < 0 && p[n]) sel = n;
    end
`endif
    return sel;
  endfunction

  task automatic model_edge(input bit rstn, input logic [3:0] y, input bit e, input bit a);
    int sel;
    if (!rstn) begin
      m_pend  = 4'b0000;
      m_valid = 1'b0;
      m_code  = 2'b00;
      m_last  = 3;
      return;
    end
    sel = choose(m_pend, m_last);
    if (e && sel >= 0 && (!m_valid || a)) begin
      m_code      = 2'(sel);
      m_valid     = 1'b1;
      m_last      = sel;
      m_pend[sel] = 1'b0;
    end else if (m_valid && a) begin
      m_valid = 1'b0;
    end
    if (e) m_pend = m_pend | y;
  endtask

  // One clock of stimulus: drive at the falling edge, predict the next posedge.
  task automatic step(input bit rstn, input logic [3:0] y, input bit e, input bit a);
    @(negedge clk);
    rst_n = rstn;
    {y3, y2, y1, y0} = y;
    en  = e;
    ack = a;
    if (!rstn) begin
      #1;
      checks++;
      if (valid !== 1'b0 || pend !== 4'b0000 || {o0, o1} !== 2'b00) begin
        errors++;
        $display("FAIL async-reset: got valid=%b code=%b%b pend=%b, expected valid=0 code=00 pend=0000",
                 valid, o0, o1, pend);
      end
    end
    model_edge(rstn, y, e, a);
    exp_q.push_back('{valid: m_valid, code: m_code, pend: m_pend});
  endtask

  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({valid, o0, o1, pend} !== e) begin
        errors++;
        $display("FAIL cycle-state @%0t: got valid=%b code=%b%b pend=%b, expected valid=%b code=%b pend=%b",
                 $time, valid, o0, o1, pend, e.valid, e.code, e.pend);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {y3, y2, y1, y0} = 4'b1000;
    en  = 1'b1;
    ack = 1'b0;
    model_edge(1'b0, 4'b0000, 1'b0, 1'b0);

    // Reset holds everything clear even with y3 and en high
    step(0, 4'b1000, 1, 0);
    step(0, 4'b1000, 1, 0);

    // Single y2 pulse, then accept
    step(1, 4'b0100, 1, 0);
    step(1, 4'b0000, 1, 0);
    step(1, 4'b0000, 1, 1);
    step(1, 4'b0000, 1, 0);

    // y0,y1,y3 together with ack held high, from a fresh pointer
    step(0, 4'b0000, 1, 0);
    step(1, 4'b1011, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 4'b0000, 1, 1);

    // HOLD on code 01 while en=0 ignores y3 and holds; ack retires
    step(1, 4'b0010, 1, 0);
    step(1, 4'b0000, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 4'b1000, 0, 0);
    step(1, 4'b1000, 0, 1);
    step(1, 4'b0000, 0, 0);

    // y1 held while its code is selected keeps pend[1]; reset in HOLD
    step(1, 4'b0010, 1, 0);
    step(1, 4'b0010, 1, 0);
    step(1, 4'b0010, 1, 0);
    step(0, 4'b0000, 1, 0);
    step(1, 4'b0000, 1, 0);

    // All lines high with ack high: top index keeps re-presenting
    for (int i = 0; i < 8; i++) step(1, 4'b1111, 1, 1);
    step(0, 4'b0000, 0, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           4'($urandom),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0));
    end

    // Drain
    for (int i = 0; i < 8; i++) step(1, 4'b0000, 1, 1);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard-drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
